// File: rtl/div_seq_signed_pkg.sv
// Shared definitions for the sequential signed divider: FSM encodings,
// default geometry and the divide-by-zero quotient pattern.
package div_seq_signed_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_seq_signed_addsub_w.sv
// N-bit combinational adder/subtractor assembled from 4-bit carry-lookahead
// slices. sub=1 inverts b and injects the +1 through the carry-in.
module addsub_w #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    localparam int NS = (N + 3) / 4;
    localparam int NP = NS * 4;

    logic [NP-1:0] a_p;
    logic [NP-1:0] b_p;
    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP-1:0] s;
    logic [NS:0]   c;
    logic          unused_bits;

    assign a_p  = NP'(a);
    assign b_p  = NP'(b ^ {N{sub}});
    assign g    = a_p & b_p;
    assign p    = a_p ^ b_p;
    assign c[0] = sub;

    for (genvar i = 0; i < NS; i++) begin : g_slice
        logic [3:0] gs;
        logic [3:0] ps;
        logic [4:0] cs;

        assign gs    = g[4*i +: 4];
        assign ps    = p[4*i +: 4];
        assign cs[0] = c[i];
        assign cs[1] = gs[0] | (ps[0] & cs[0]);
        assign cs[2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & cs[0]);
        assign cs[3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                     | (ps[2] & ps[1] & ps[0] & cs[0]);
        assign cs[4] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                     | (ps[3] & ps[2] & ps[1] & gs[0]) | ((&ps) & cs[0]);
        assign s[4*i +: 4] = ps ^ cs[3:0];
        assign c[i+1]      = cs[4];
    end

    // Carry-out and padding bits of the last slice are not needed.
    assign unused_bits = ^{c[NS], s};
    assign sum         = s[N-1:0];

endmodule

// File: rtl/div_seq_signed.sv
// Iterative signed divider (non-restoring, one quotient bit per clock).
// Optional build macro: DIV_UNSIGNED_EN adds an is_unsigned input that
// bypasses sign handling so operands are divided as unsigned magnitudes.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// CALC   | WIDTH add/subtract iterations
// FIX    | remainder correction, sign fix-up, load outputs
// DONE   | done pulse, results valid
module div_seq_signed
    import div_seq_signed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             signed_op;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   add_a;
    logic             add_sub;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   p_corr;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Shared adder operand select: shifted step in CALC, correction in FIX.
    // The add/subtract decision uses the sign of P before the shift; any wrap
    // of the shifted value is undone by the step since the result fits.
    always_comb begin
        p_sh    = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        add_a   = p_sh;
        add_sub = ~p_q[WIDTH];
        if (state_q == S_FIX) begin
            add_a   = p_q;
            add_sub = 1'b0;
        end
    end

    addsub_w #(.N(WIDTH + 1)) u_addsub (
        .a   (add_a),
        .b   ({1'b0, d_q}),
        .sub (add_sub),
        .sum (add_sum)
    );

    // Next-state, datapath update and result loading.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        p_d           = p_q;
        q_d           = q_q;
        d_d           = d_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dz_d          = dz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        p_corr        = p_q[WIDTH] ? add_sum : p_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_quo_d     = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d     = signed_op & dividend[WIDTH-1];
                    dz_d          = (divisor == '0);
                    div_by_zero_d = 1'b0;
                    p_d           = '0;
                    cnt_d         = CNT_W'(WIDTH);
                    // Divide by zero skips CALC but still passes through FIX,
                    // where the raw dividend parked in q becomes the remainder.
                    if (divisor == '0) begin
                        q_d     = dividend;
                        d_d     = '0;
                        state_d = S_FIX;
                    end else begin
                        q_d     = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
                        d_d     = (signed_op & divisor[WIDTH-1])  ? -divisor  : divisor;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                p_d   = add_sum;
                q_d   = {q_q[WIDTH-2:0], ~add_sum[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    quotient_d    = DIV0_QUOTIENT[WIDTH-1:0];
                    remainder_d   = q_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d  = neg_quo_q ? -q_q : q_q;
                    remainder_d = neg_rem_q ? -p_corr[WIDTH-1:0] : p_corr[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            p_q           <= '0;
            q_q           <= '0;
            d_q           <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dz_q          <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p_q           <= p_d;
            q_q           <= q_d;
            d_q           <= d_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dz_q          <= dz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_seq_signed.sv
// Directed bench for div_seq_signed: vector table plus hand-written
// sequences for re-pulsed start, start during done and mid-run reset.
module tb_div_seq_signed;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
`ifdef DIV_UNSIGNED_EN
    logic        is_unsigned = 1'b0;
`endif

    div_seq_signed dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one operation at a falling edge and wait (bounded) for done.
    // p1/p2 name cycles at which start is re-pulsed with other operands.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int p1, input int p2,
                          output int lat, output int busy_cnt);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clock);
            start = (cyc == p1) || (cyc == p2);
            if (start) begin
                dividend = 32'd50;
                divisor  = 32'd3;
            end
            if (done) begin
                lat   = cyc;
                start = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;

        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
        vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34};
        vecs[3]  = '{32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        1'b1, 2};
        vecs[4]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 34};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
        vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34};
        vecs[7]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34};
        vecs[8]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34};
        vecs[9]  = '{32'd5,        32'd10,       32'd0,        32'd5,        1'b0, 34};
        vecs[10] = '{32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2};
        vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 34};
        vecs[12] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 34};
        vecs[13] = '{32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 1'b0, 34};
        vecs[14] = '{32'h7FFFFFFF, 32'd7,        32'h12492492, 32'd1,        1'b0, 34};
        vecs[15] = '{32'h80000000, 32'd7,        32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0, 34};

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clock);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, 0, lat, bc);
            check($sformatf("v%0d quotient", i), quotient, vecs[i].q);
            check($sformatf("v%0d remainder", i), remainder, vecs[i].r);
            check($sformatf("v%0d div_by_zero", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d busy cycles", i), bc, vecs[i].lat - 1);
            check($sformatf("v%0d busy at done", i), {31'd0, busy}, 32'd0);
            @(negedge clock);
            check($sformatf("v%0d done pulse width", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d quotient hold", i), quotient, vecs[i].q);
        end

        // start re-pulsed mid-operation must be ignored
        run_op(32'd100, 32'd7, 5, 20, lat, bc);
        check("repulse quotient", quotient, 32'd14);
        check("repulse remainder", remainder, 32'd2);
        check("repulse latency", lat, 34);
        check("repulse busy cycles", bc, 33);

        // start asserted during the done cycle must be ignored
        run_op(32'd100, 32'd7, 0, 0, lat, bc);
        check("done-start latency", lat, 34);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("done-start busy c%0d", k), {31'd0, busy}, 32'd0);
        end
        check("done-start quotient hold", quotient, 32'd14);
        check("done-start remainder hold", remainder, 32'd2);

        // reset in cycle 10 of an operation
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("midreset busy before", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        check("midreset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        bc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done) bc++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) bc++;
        end
        check("midreset no done", bc, 0);
        run_op(32'hFFFFFF9C, 32'd7, 0, 0, lat, bc);
        check("post-reset quotient", quotient, 32'hFFFFFFF2);
        check("post-reset remainder", remainder, 32'hFFFFFFFE);
        check("post-reset latency", lat, 34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
